// File: rtl/alu_bist.sv
// Built-in self test for the ALUControl+alu pair.
// Walks a 9-entry vector ROM and counts result mismatches.
module alu_bist #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter bit          STOP_ON_FAIL  = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [3:0]  func_code,
  output logic [6:0]  opcode,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  input  logic [31:0] alu_out,
  input  logic        branch_enable,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  fail_count,
  output logic [3:0]  fail_index,
  output logic [3:0]  vec_index
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam logic [3:0] SETTLE  = 4'(SETTLE_CYCLES);
  localparam logic [3:0] LAST    = 4'd8;
  localparam logic [6:0] OP_REG  = 7'b0110011;

  state_e      state_q, state_d;
  logic [3:0]  vec_q, vec_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic [3:0]  fidx_q, fidx_d;
  logic        done_q, done_d;

  logic [3:0]  rom_fc;
  logic [31:0] rom_a;
  logic [31:0] rom_b;
  logic [31:0] rom_exp;
  logic        mism;

  // Vector ROM: operands and expected result for the current index
  always_comb begin
    rom_fc  = 4'b0000;
    rom_a   = 32'd0;
    rom_b   = 32'd0;
    rom_exp = 32'd0;
    case (vec_q)
      4'd0: begin rom_fc = 4'b0111; rom_a = 32'h0F;   rom_b = 32'h55; rom_exp = 32'h05;   end
      4'd1: begin rom_fc = 4'b0110; rom_a = 32'h0F;   rom_b = 32'h55; rom_exp = 32'h5F;   end
      4'd2: begin rom_fc = 4'b0000; rom_a = 32'd10000; rom_b = 32'd111; rom_exp = 32'd10111; end
      4'd3: begin rom_fc = 4'b1000; rom_a = 32'd10000; rom_b = 32'd111; rom_exp = 32'd9889;  end
      4'd4: begin rom_fc = 4'b0010; rom_a = 32'd0;    rom_b = 32'd2;  rom_exp = 32'd1;    end
      4'd5: begin rom_fc = 4'b0101; rom_a = 32'd16;   rom_b = 32'd2;  rom_exp = 32'd4;    end
      4'd6: begin rom_fc = 4'b1101; rom_a = 32'd8;    rom_b = 32'd1;  rom_exp = 32'd4;    end
      4'd7: begin rom_fc = 4'b0001; rom_a = 32'd2;    rom_b = 32'd2;  rom_exp = 32'd8;    end
      4'd8: begin rom_fc = 4'b0100; rom_a = 32'h55;   rom_b = 32'hFF; rom_exp = 32'hAA;   end
      default: begin rom_fc = 4'b0000; rom_a = 32'd0; rom_b = 32'd0; rom_exp = 32'd0; end
    endcase
  end

  assign mism = (alu_out != rom_exp) || branch_enable;

  // State, vector pointer, settle counter and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      vec_q   <= 4'd0;
      cnt_q   <= 4'd0;
      fcnt_q  <= 4'd0;
      fidx_q  <= 4'hF;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      fidx_q  <= fidx_d;
      done_q  <= done_d;
    end
  end

  // Next-state: accept start outside RUN, sample each vector after settling
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    fidx_d  = fidx_q;
    done_d  = done_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          vec_d   = 4'd0;
          cnt_d   = 4'd1;
          fcnt_d  = 4'd0;
          fidx_d  = 4'hF;
          done_d  = 1'b0;
        end
      end
      RUN: begin
        if (cnt_q >= SETTLE) begin
          cnt_d = 4'd1;
          if (mism) begin
            if (fcnt_q != 4'hF) fcnt_d = fcnt_q + 4'd1;
            if (fcnt_q == 4'd0) fidx_d = vec_q;
          end
          if (vec_q == LAST || (STOP_ON_FAIL && mism)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            vec_d = vec_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q == RUN);
  assign func_code  = busy ? rom_fc : 4'd0;
  assign opcode     = busy ? OP_REG : 7'd0;
  assign op_a       = busy ? rom_a : 32'd0;
  assign op_b       = busy ? rom_b : 32'd0;
  assign done       = done_q;
  assign pass       = done_q && (fcnt_q == 4'd0);
  assign fail_count = fcnt_q;
  assign fail_index = fidx_q;
  assign vec_index  = vec_q;

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: behavioural ALU with fault injection,
// run-level scoreboard of expected completion results.
module tb_alu_bist;

  localparam int S = 2;

  logic clk = 1'b0;
  logic reset;
  logic st;
  bit   sel;
  int   fault;

  logic start_a, start_b;
  logic [3:0]  fc_a, fc_b, fcnt_a, fcnt_b, fidx_a, fidx_b, vi_a, vi_b;
  logic [6:0]  opc_a, opc_b;
  logic [31:0] a_a, b_a, a_b, b_b, out_a, out_b;
  logic        be_a, be_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b;

  logic [3:0]  fc_m, fcnt_m, fidx_m, vi_m;
  logic [6:0]  opc_m;
  logic [31:0] a_m, b_m;
  logic        busy_m, done_m, pass_m;

  logic [3:0]  t_fc [9] = '{4'b0111, 4'b0110, 4'b0000, 4'b1000,
                            4'b0010, 4'b0101, 4'b1101, 4'b0001, 4'b0100};
  logic [31:0] t_a  [9] = '{32'h0F, 32'h0F, 32'd10000, 32'd10000,
                            32'd0, 32'd16, 32'd8, 32'd2, 32'h55};
  logic [31:0] t_b  [9] = '{32'h55, 32'h55, 32'd111, 32'd111,
                            32'd2, 32'd2, 32'd1, 32'd2, 32'hFF};
  logic [31:0] t_e  [9] = '{32'h05, 32'h5F, 32'd10111, 32'd9889,
                            32'd1, 32'd4, 32'd4, 32'd8, 32'hAA};

  typedef struct {
    string tag;
    int    lat;
    int    fc;
    int    fi;
    int    ps;
    int    lv;
  } exp_t;
  exp_t sbq[$];

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign start_a = st & ~sel;
  assign start_b = st & sel;

  alu_bist #(.SETTLE_CYCLES(S), .STOP_ON_FAIL(1'b0)) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .func_code(fc_a), .opcode(opc_a), .op_a(a_a), .op_b(b_a),
    .alu_out(out_a), .branch_enable(be_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_count(fcnt_a), .fail_index(fidx_a), .vec_index(vi_a)
  );

  alu_bist #(.SETTLE_CYCLES(S), .STOP_ON_FAIL(1'b1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .func_code(fc_b), .opcode(opc_b), .op_a(a_b), .op_b(b_b),
    .alu_out(out_b), .branch_enable(be_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_count(fcnt_b), .fail_index(fidx_b), .vec_index(vi_b)
  );

  function automatic logic [31:0] alu_f(input logic [3:0] f,
                                        input logic [6:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    r = 32'd0;
    if (op == 7'b0110011) begin
      case (f)
        4'b0000: r = a + b;
        4'b1000: r = a - b;
        4'b0111: r = a & b;
        4'b0110: r = a | b;
        4'b0100: r = a ^ b;
        4'b0001: r = a << b[4:0];
        4'b0101: r = a >> b[4:0];
        4'b1101: r = $signed(a) >>> b[4:0];
        4'b0010: r = {31'd0, $signed(a) < $signed(b)};
        4'b0011: r = {31'd0, a < b};
        default: r = 32'd0;
      endcase
    end
    return r;
  endfunction

  always_comb begin
    out_a = alu_f(fc_a, opc_a, a_a, b_a);
    out_b = alu_f(fc_b, opc_b, a_b, b_b);
    if (fault == 1) begin
      out_a[0] = 1'b0;
      out_b[0] = 1'b0;
    end
    be_a = (fault == 2);
    be_b = (fault == 2);
  end

  always_comb begin
    fc_m   = sel ? fc_b   : fc_a;
    opc_m  = sel ? opc_b  : opc_a;
    a_m    = sel ? a_b    : a_a;
    b_m    = sel ? b_b    : b_a;
    fcnt_m = sel ? fcnt_b : fcnt_a;
    fidx_m = sel ? fidx_b : fidx_a;
    vi_m   = sel ? vi_b   : vi_a;
    busy_m = sel ? busy_b : busy_a;
    done_m = sel ? done_b : done_a;
    pass_m = sel ? pass_b : pass_a;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic push_exp(input string tag, input bit stop);
    exp_t e;
    logic [31:0] r;
    bit bad;
    e.tag = tag;
    e.fc = 0;
    e.fi = 15;
    e.lat = 9 * S;
    e.lv = 8;
    for (int i = 0; i < 9; i++) begin
      r = t_e[i];
      if (fault == 1) r[0] = 1'b0;
      bad = (r != t_e[i]) || (fault == 2);
      if (bad) begin
        if (e.fc == 0) e.fi = i;
        e.fc++;
        if (stop) begin
          e.lat = (i + 1) * S;
          e.lv = i;
          break;
        end
      end
    end
    e.ps = (e.fc == 0);
    sbq.push_back(e);
  endtask

  task automatic run(input bit sb, input string tag, input int restart_at);
    int c;
    bit got;
    exp_t e;
    sel = sb;
    push_exp(tag, sb);
    @(negedge clk);
    st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    chk({tag, "_acc_done"}, 32'(done_m), 32'd0);
    chk({tag, "_acc_busy"}, 32'(busy_m), 32'd1);
    c = 0;
    got = 1'b0;
    while (c < 100) begin
      if (done_m) begin
        got = 1'b1;
        break;
      end
      if (!sb && fault == 0 && (c % S) == 0 && c / S < 9) begin
        chk({tag, "_vi"}, 32'(vi_m), 32'(c / S));
        chk({tag, "_fc"}, 32'(fc_m), 32'(t_fc[c / S]));
        chk({tag, "_opa"}, a_m, t_a[c / S]);
        chk({tag, "_opb"}, b_m, t_b[c / S]);
        chk({tag, "_opc"}, 32'(opc_m), 32'h33);
      end
      st = (c == restart_at);
      @(negedge clk);
      c++;
    end
    st = 1'b0;
    e = sbq.pop_front();
    if (!got) chk({e.tag, "_timeout"}, 32'd0, 32'd1);
    chk({e.tag, "_lat"}, 32'(c), 32'(e.lat));
    chk({e.tag, "_fcnt"}, 32'(fcnt_m), 32'(e.fc));
    chk({e.tag, "_fidx"}, 32'(fidx_m), 32'(e.fi));
    chk({e.tag, "_pass"}, 32'(pass_m), 32'(e.ps));
    chk({e.tag, "_busy"}, 32'(busy_m), 32'd0);
    chk({e.tag, "_vi_hold"}, 32'(vi_m), 32'(e.lv));
    chk({e.tag, "_opa0"}, a_m, 32'd0);
    chk({e.tag, "_fc0"}, 32'(fc_m), 32'd0);
    chk({e.tag, "_opc0"}, 32'(opc_m), 32'd0);
  endtask

  task automatic rst_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy_a), 32'd0);
    chk({tag, "_done"}, 32'(done_a), 32'd0);
    chk({tag, "_pass"}, 32'(pass_a), 32'd0);
    chk({tag, "_fcnt"}, 32'(fcnt_a), 32'd0);
    chk({tag, "_fidx"}, 32'(fidx_a), 32'hF);
    chk({tag, "_vi"}, 32'(vi_a), 32'd0);
    chk({tag, "_fc"}, 32'(fc_a), 32'd0);
    chk({tag, "_opc"}, 32'(opc_a), 32'd0);
    chk({tag, "_opa"}, a_a, 32'd0);
    chk({tag, "_opb"}, b_a, 32'd0);
    chk({tag, "_b_fidx"}, 32'(fidx_b), 32'hF);
    chk({tag, "_b_busy"}, 32'(busy_b), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    st = 1'b0;
    sel = 1'b0;
    fault = 0;
    #2;
    rst_vals("rst");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy_a), 32'd0);
    chk("idle_done", 32'(done_a), 32'd0);

    run(1'b0, "good", -1);
    run(1'b0, "restart_in_done", -1);
    run(1'b0, "start_in_run", 5);

    fault = 1;
    run(1'b0, "bit0", -1);
    run(1'b1, "bit0_stop", -1);
    fault = 2;
    run(1'b0, "be1", -1);
    run(1'b1, "be1_stop", -1);

    fault = 0;
    sel = 1'b0;
    @(negedge clk);
    st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    repeat (7) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    rst_vals("midrst");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", 32'(busy_a), 32'd0);
    run(1'b0, "after_rst", -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
